// File: rtl/psum_acc_wb_pkg.sv
// Shared definitions for the psum accumulate / write-back block:
// the controller state encoding and the default datapath widths.
package psum_acc_wb_pkg;

  localparam int DEFAULT_DATA_BITWIDTH = 16;
  localparam int DEFAULT_ADDR_BITWIDTH = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    RD      = 2'd2,
    WR      = 2'd3
  } state_t;

endpackage

// File: rtl/psum_acc_wb_if.sv
// Bus bundle between the psum accumulator, its controller, the PE array
// and the psum GLB. The slave modport is the accumulator's view; the
// master modport is the view of everything around it.
interface psum_acc_wb_if
  import psum_acc_wb_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH
);

  logic                     start;
  logic                     first_pass;
  logic [ADDR_BITWIDTH-1:0] base_addr;
  logic [ADDR_BITWIDTH-1:0] num_psum;
  logic [DATA_BITWIDTH-1:0] psum_in;
  logic                     psum_valid;
  logic                     psum_ready;
  logic                     glb_read_req;
  logic [ADDR_BITWIDTH-1:0] glb_r_addr;
  logic [DATA_BITWIDTH-1:0] glb_r_data;
  logic                     glb_write_en;
  logic [ADDR_BITWIDTH-1:0] glb_w_addr;
  logic [DATA_BITWIDTH-1:0] glb_w_data;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, first_pass, base_addr, num_psum,
    input  psum_in, psum_valid, glb_r_data,
    output psum_ready, glb_read_req, glb_r_addr,
    output glb_write_en, glb_w_addr, glb_w_data,
    output busy, done
  );

  modport master (
    output start, first_pass, base_addr, num_psum,
    output psum_in, psum_valid, glb_r_data,
    input  psum_ready, glb_read_req, glb_r_addr,
    input  glb_write_en, glb_w_addr, glb_w_data,
    input  busy, done
  );

endinterface

// File: rtl/psum_acc_wb_adder.sv
// psum_adder: combinational signed adder that merges an incoming psum
// with the value already held in the GLB.
// Build option PSUM_SAT_EN: when defined the sum clamps to the most
// positive / most negative word on overflow; otherwise it wraps.
module psum_adder #(
  parameter int DATA_BITWIDTH = 16
) (
  input  logic [DATA_BITWIDTH-1:0] a,
  input  logic [DATA_BITWIDTH-1:0] b,
  output logic [DATA_BITWIDTH-1:0] sum
);

`ifdef PSUM_SAT_EN
  localparam logic [DATA_BITWIDTH-1:0] MAX_VAL = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
  localparam logic [DATA_BITWIDTH-1:0] MIN_VAL = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};

  logic [DATA_BITWIDTH:0] wide_sum;

  assign wide_sum = {a[DATA_BITWIDTH-1], a} + {b[DATA_BITWIDTH-1], b};

  // Overflow shows up as the two top bits of the sign-extended sum disagreeing.
  always_comb begin
    sum = wide_sum[DATA_BITWIDTH-1:0];
    if (wide_sum[DATA_BITWIDTH] != wide_sum[DATA_BITWIDTH-1]) begin
      sum = wide_sum[DATA_BITWIDTH] ? MIN_VAL : MAX_VAL;
    end
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/psum_acc_wb.sv
// psum_acc_wb: takes psums from the PE array one at a time and writes
// them to consecutive GLB words starting at base_addr, either replacing
// the stored value (first pass) or adding to it (read, add, write).
// Build option PSUM_SAT_EN selects saturating accumulation in psum_adder.
// The interface widths must match DATA_BITWIDTH / ADDR_BITWIDTH.
module psum_acc_wb
  import psum_acc_wb_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH
) (
  input  logic           clk,
  input  logic           reset,
  psum_acc_wb_if.slave   bus
);

  localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE = ADDR_BITWIDTH'(1);

  state_t                   state;
  logic [ADDR_BITWIDTH-1:0] base_q;
  logic [ADDR_BITWIDTH-1:0] num_q;
  logic [ADDR_BITWIDTH-1:0] idx_q;
  logic                     first_q;
  logic [DATA_BITWIDTH-1:0] cap_q;

  logic                     psum_ready_q;
  logic                     read_req_q;
  logic [ADDR_BITWIDTH-1:0] r_addr_q;
  logic                     write_en_q;
  logic [ADDR_BITWIDTH-1:0] w_addr_q;
  logic                     busy_q;
  logic                     done_q;

  logic [ADDR_BITWIDTH-1:0] cur_addr;
  logic [DATA_BITWIDTH-1:0] acc_sum;

  // Address arithmetic is naturally modulo 2^ADDR_BITWIDTH.
  assign cur_addr = base_q + idx_q;

  psum_adder #(
    .DATA_BITWIDTH (DATA_BITWIDTH)
  ) u_adder (
    .a   (cap_q),
    .b   (bus.glb_r_data),
    .sum (acc_sum)
  );

  // Pass controller: every strobe and address is registered on entry to the
  // state that owns it, so each one is high for exactly that one state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base_q       <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      cap_q        <= '0;
      psum_ready_q <= 1'b0;
      read_req_q   <= 1'b0;
      r_addr_q     <= '0;
      write_en_q   <= 1'b0;
      w_addr_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      psum_ready_q <= 1'b0;
      read_req_q   <= 1'b0;
      r_addr_q     <= '0;
      write_en_q   <= 1'b0;
      w_addr_q     <= '0;
      done_q       <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_psum == '0) begin
              done_q <= 1'b1;
            end else begin
              base_q       <= bus.base_addr;
              num_q        <= bus.num_psum;
              first_q      <= bus.first_pass;
              idx_q        <= '0;
              busy_q       <= 1'b1;
              psum_ready_q <= 1'b1;
              state        <= WAIT_IN;
            end
          end
        end

        WAIT_IN: begin
          if (bus.psum_valid) begin
            cap_q <= bus.psum_in;
            if (first_q) begin
              write_en_q <= 1'b1;
              w_addr_q   <= cur_addr;
              state      <= WR;
            end else begin
              read_req_q <= 1'b1;
              r_addr_q   <= cur_addr;
              state      <= RD;
            end
          end else begin
            psum_ready_q <= 1'b1;
          end
        end

        RD: begin
          write_en_q <= 1'b1;
          w_addr_q   <= cur_addr;
          state      <= WR;
        end

        WR: begin
          idx_q <= idx_q + ADDR_ONE;
          if (idx_q == num_q - ADDR_ONE) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            psum_ready_q <= 1'b1;
            state        <= WAIT_IN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.psum_ready   = psum_ready_q;
  assign bus.glb_read_req = read_req_q;
  assign bus.glb_r_addr   = r_addr_q;
  assign bus.glb_write_en = write_en_q;
  assign bus.glb_w_addr   = w_addr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // GLB read data is only looked at while the write strobe is up (WR state).
  assign bus.glb_w_data = !write_en_q ? '0 : (first_q ? cap_q : acc_sum);

endmodule

// File: tb/tb_psum_acc_wb.sv
// Testbench for psum_acc_wb. Acts as PE array, controller and GLB.
// Honours the PSUM_SAT_EN build option in its reference arithmetic.
module tb_psum_acc_wb;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic reset;

  psum_acc_wb_if #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(10)) bus ();

  psum_acc_wb #(
    .DATA_BITWIDTH (16),
    .ADDR_BITWIDTH (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] glb_mem   [1024];
  logic [15:0] model_mem [1024];
  logic [9:0]  exp_rq [$];
  wr_t         exp_wq [$];
  wr_t         cur_wr;

  int n_checks = 0;
  int n_fails  = 0;
  int cycle    = 0;
  int access_cnt   = 0;
  int write_cnt    = 0;
  int done_seen    = 0;
  int done_pending = 0;
  int pass_writes  = 0;
  int last_write   = 0;
  int exp_spacing  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB: one-cycle read latency; junk on the data bus when not reading.
  always @(posedge clk) begin
    if (bus.glb_write_en) glb_mem[bus.glb_w_addr] <= bus.glb_w_data;
    bus.glb_r_data <= bus.glb_read_req ? glb_mem[bus.glb_r_addr] : 16'hDEAD;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic for one accumulate step.
  function automatic logic [15:0] model_acc(input logic [15:0] g, input logic [15:0] p);
    int s;
    s = int'($signed(g)) + int'($signed(p));
`ifdef PSUM_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Compare process: every GLB access and done pulse against the model.
  always @(negedge clk) begin
    cycle++;
    if (bus.glb_read_req) begin
      access_cnt++;
      if (exp_rq.size() == 0) checkOutput("unexpected_read", 32'(bus.glb_r_addr), 32'h0);
      else checkOutput("read_addr", 32'(bus.glb_r_addr), 32'(exp_rq.pop_front()));
    end
    if (bus.glb_write_en) begin
      access_cnt++;
      write_cnt++;
      if (exp_wq.size() == 0) begin
        checkOutput("unexpected_write", 32'(bus.glb_w_addr), 32'h0);
      end else begin
        cur_wr = exp_wq.pop_front();
        checkOutput("write_addr", 32'(bus.glb_w_addr), 32'(cur_wr.addr));
        checkOutput("write_data", 32'(bus.glb_w_data), 32'(cur_wr.data));
        model_mem[cur_wr.addr] = cur_wr.data;
      end
      if (pass_writes > 0 && exp_spacing > 0)
        checkOutput("write_spacing", 32'(cycle - last_write), 32'(exp_spacing));
      pass_writes++;
      last_write = cycle;
    end
    if (bus.done) begin
      done_seen++;
      checkOutput("done_expected", 32'(done_pending > 0), 32'h1);
      if (done_pending > 0) done_pending--;
    end
  end

  // One full pass: builds the expected traffic, then plays the PE array.
  task automatic applyStimulus(input bit first, input int base, input int num,
                               input int n_stall, input bit inject_start,
                               input logic [15:0] pv [4]);
    int d0;
    int k;
    int acc0;
    logic [9:0] a;
    for (int i = 0; i < num; i++) begin
      a = 10'((base + i) % 1024);
      if (!first) exp_rq.push_back(a);
      exp_wq.push_back('{addr: a, data: first ? pv[i] : model_acc(model_mem[a], pv[i])});
    end
    done_pending++;
    pass_writes = 0;
    exp_spacing = (n_stall == 0) ? (first ? 2 : 3) : 0;
    d0 = done_seen;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.first_pass = first;
    bus.base_addr  = 10'(base);
    bus.num_psum   = 10'(num);
    @(negedge clk);
    bus.start = 1'b0;
    if (num > 0) checkOutput("busy_after_start", 32'(bus.busy), 32'h1);

    for (int i = 0; i < num; i++) begin
      k = 0;
      while (!bus.psum_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      checkOutput("ready_wait", 32'(bus.psum_ready), 32'h1);
      if (i == 0 && n_stall > 0) begin
        acc0 = access_cnt;
        repeat (n_stall) @(negedge clk);
        checkOutput("stall_no_glb", 32'(access_cnt), 32'(acc0));
        checkOutput("stall_ready", 32'(bus.psum_ready), 32'h1);
      end
      bus.psum_valid = 1'b1;
      bus.psum_in    = pv[i];
      @(negedge clk);
      bus.psum_valid = 1'b0;
      if (inject_start && i == 0) begin
        bus.start    = 1'b1;
        bus.num_psum = 10'd0;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.num_psum = 10'(num);
      end
    end

    k = 0;
    while (done_seen == d0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done_count", 32'(done_seen - d0), 32'h1);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(bus.done), 32'h0);
    checkOutput("busy_after_done", 32'(bus.busy), 32'h0);
    checkOutput("pending_writes", 32'(exp_wq.size()), 32'h0);
    checkOutput("pending_reads", 32'(exp_rq.size()), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ready"},   32'(bus.psum_ready),   32'h0);
    checkOutput({tag, "_rreq"},    32'(bus.glb_read_req), 32'h0);
    checkOutput({tag, "_raddr"},   32'(bus.glb_r_addr),   32'h0);
    checkOutput({tag, "_wen"},     32'(bus.glb_write_en), 32'h0);
    checkOutput({tag, "_waddr"},   32'(bus.glb_w_addr),   32'h0);
    checkOutput({tag, "_wdata"},   32'(bus.glb_w_data),   32'h0);
    checkOutput({tag, "_busy"},    32'(bus.busy),         32'h0);
    checkOutput({tag, "_done"},    32'(bus.done),         32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    int wr0;
    int d0;
    int k;
    for (int i = 0; i < 1024; i++) model_mem[i] = 16'h0;
    bus.start      = 1'b0;
    bus.first_pass = 1'b0;
    bus.base_addr  = '0;
    bus.num_psum   = '0;
    bus.psum_in    = '0;
    bus.psum_valid = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] first pass with input stall");
    applyStimulus(1'b1, 0, 3, 4, 1'b0, '{16'd5, 16'd6, 16'd7, 16'd0});
    checkOutput("pin_mem0_first", 32'(glb_mem[0]), 32'd5);
    checkOutput("pin_mem1_first", 32'(glb_mem[1]), 32'd6);
    checkOutput("pin_mem2_first", 32'(glb_mem[2]), 32'd7);

    $display("[TB] accumulate pass with start while busy");
    applyStimulus(1'b0, 0, 3, 0, 1'b1, '{16'd1, 16'd2, 16'd3, 16'd0});
    checkOutput("pin_mem0_acc", 32'(glb_mem[0]), 32'd6);
    checkOutput("pin_mem1_acc", 32'(glb_mem[1]), 32'd8);
    checkOutput("pin_mem2_acc", 32'(glb_mem[2]), 32'd10);

    $display("[TB] overflow behaviour");
    applyStimulus(1'b1, 20, 2, 0, 1'b0, '{16'h7FF0, 16'h8000, 16'h0, 16'h0});
    applyStimulus(1'b0, 20, 2, 0, 1'b0, '{16'h0020, 16'hFFFF, 16'h0, 16'h0});
`ifdef PSUM_SAT_EN
    checkOutput("pin_sat_pos", 32'(glb_mem[20]), 32'h7FFF);
    checkOutput("pin_sat_neg", 32'(glb_mem[21]), 32'h8000);
`else
    checkOutput("pin_wrap_pos", 32'(glb_mem[20]), 32'h8010);
    checkOutput("pin_wrap_neg", 32'(glb_mem[21]), 32'h7FFF);
`endif

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1022, 4, 0, 1'b0, '{16'd11, 16'd12, 16'd13, 16'd14});
    applyStimulus(1'b0, 1022, 4, 0, 1'b0, '{16'd1, 16'd1, 16'd1, 16'd1});
    checkOutput("pin_wrap_1022", 32'(glb_mem[1022]), 32'd12);
    checkOutput("pin_wrap_1023", 32'(glb_mem[1023]), 32'd13);
    checkOutput("pin_wrap_0",    32'(glb_mem[0]),    32'd14);
    checkOutput("pin_wrap_1",    32'(glb_mem[1]),    32'd15);

    $display("[TB] empty pass");
    acc0 = access_cnt;
    applyStimulus(1'b0, 7, 0, 0, 1'b0, '{16'd0, 16'd0, 16'd0, 16'd0});
    checkOutput("empty_no_glb", 32'(access_cnt), 32'(acc0));

    $display("[TB] reset during read");
    exp_rq.push_back(10'd10);
    pass_writes = 0;
    exp_spacing = 0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.first_pass = 1'b0;
    bus.base_addr  = 10'd10;
    bus.num_psum   = 10'd3;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.psum_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.psum_valid = 1'b1;
    bus.psum_in    = 16'd7;
    @(negedge clk);
    bus.psum_valid = 1'b0;
    checkOutput("rd_before_reset", 32'(bus.glb_read_req), 32'h1);
    wr0 = write_cnt;
    d0  = done_seen;
    #2 reset = 1'b0;
    #1 check_all_zero("midpass");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("abandon_no_write", 32'(write_cnt), 32'(wr0));
    checkOutput("abandon_no_done", 32'(done_seen), 32'(d0));
    checkOutput("abandon_reads", 32'(exp_rq.size()), 32'h0);

    $display("[TB] pass after reset");
    applyStimulus(1'b1, 5, 1, 0, 1'b0, '{16'd99, 16'd0, 16'd0, 16'd0});
    checkOutput("pin_mem5", 32'(glb_mem[5]), 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
